calc_controller: RTL and testbench
==================================

CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock  in  1  single clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Key_enter  in  1  already-debounced one-cycle enter pulse.
- Switches  in  8  operand value from the user.
- Op  in  2  operation code from the user; passed to the ALU unchanged.
- Alu_A, Alu_B  out  8 each  registered operands driven to the ALU.
- Alu_op  out  2  registered opcode driven to the ALU.
- Alu_start  out  1  one-cycle ALU launch pulse.
- Alu_done  in  1  ALU completion; sampled only in EXEC.
- Alu_result  in  8  ALU result; valid while Alu_done=1.
- Alu_overflow, Alu_carry  in  1 each  ALU flags; valid while Alu_done=1.
- Units, Tens  out  4 each  BCD digits of the displayed result.
- Hundreds  out  2  BCD hundreds digit, 0..2.
- Zero, Overflow, Carry_out  out  1 each  flags feeding the display decoder.
- Busy  out  1  high in EXEC and CONV.

Function
REQ-002 The FSM SHALL have six states: WAIT_A, WAIT_B, WAIT_OP, EXEC, CONV, SHOW.
REQ-003 In WAIT_A, a Key_enter pulse SHALL latch Switches into Alu_A and move the FSM to WAIT_B.
REQ-004 In WAIT_B, a Key_enter pulse SHALL latch Switches into Alu_B and move the FSM to WAIT_OP.
REQ-005 In WAIT_OP, a Key_enter pulse SHALL latch Op into Alu_op, drive Alu_start=1 for exactly the next cycle, and move the FSM to EXEC.
REQ-006 Alu_done SHALL be ignored outside EXEC; the first cycle it can be sampled is the cycle in which Alu_start is high.
REQ-007 On edge k, where EXEC samples Alu_done=1, the block SHALL capture Alu_result, Alu_overflow and Alu_carry internally and move to CONV.
REQ-008 CONV SHALL convert the captured result to BCD by shift-add-3, one bit per cycle, on edges k+1..k+8.
REQ-009 On edge k+8, Units, Tens, Hundreds, Overflow and Carry_out SHALL update together, Zero SHALL be set to (result==0), and the FSM SHALL enter SHOW.
REQ-010 Display outputs and flags SHALL hold their last value in every state except at the REQ-009 update, including during entry of the next calculation.
REQ-011 In SHOW, a Key_enter pulse SHALL return the FSM to WAIT_A.
REQ-012 Key_enter SHALL be ignored in EXEC and CONV, with no state or register change.
REQ-013 The conversion SHALL be exact for all results 0..255; Hundreds never exceeds 2.
REQ-014 Alu_A, Alu_B and Alu_op SHALL hold stable from capture until the next capture of the same register.

Reset
REQ-015 Reset_n=0 SHALL immediately (asynchronously) force the FSM to WAIT_A and clear every output and internal register to 0, including Alu_start and Busy.
REQ-016 Reset asserted mid-EXEC or mid-CONV SHALL abort the operation; after release, no display update occurs until a full new sequence completes.

Configuration
REQ-017 With macro CALC_TIMEOUT_EN defined, a 4-bit watchdog SHALL count EXEC cycles from Alu_start.
- If 16 cycles pass without Alu_done, the FSM SHALL go to SHOW.
- On that transition it SHALL set Overflow=1, Carry_out=0, Zero=0 and Units=Tens=Hundreds=0.
REQ-018 Without CALC_TIMEOUT_EN, EXEC SHALL wait for Alu_done indefinitely, and no watchdog logic SHALL be synthesized.

Verification
REQ-019 A=200, B=55, Op=00; ALU returns 255 with no flags -> Hundreds=2, Tens=5, Units=5, Zero=0, exactly 8 cycles after the Alu_done edge.
REQ-020 ALU returns 0 with carry=1 -> Units=Tens=Hundreds=0, Zero=1, Carry_out=1, Overflow=0.
REQ-021 Key_enter pulsed in every EXEC and CONV cycle -> no state skip; result identical to a run without the pulses; Busy=1 throughout.
REQ-022 Reset_n pulsed low at CONV cycle 4 after a prior display of 123 -> all outputs 0 immediately; FSM in WAIT_A after release.
REQ-023 CALC_TIMEOUT_EN defined and Alu_done held 0 -> SHOW with Overflow=1 and digits 0 after 16 EXEC cycles; macro undefined -> still in EXEC after 100 cycles.
REQ-024 The ALU returns 99, then a new sequence runs -> outputs stay 0/9/9 through WAIT_A..EXEC and change only at the new REQ-009 edge.

Source files
------------

// File: rtl/calc_controller.sv
// calc_controller: operand/opcode entry FSM driving an external ALU, then shift-add-3 BCD display.
// Optional EXEC watchdog is enabled by defining CALC_TIMEOUT_EN.
module calc_controller (
    input  logic       clock,
    input  logic       Reset_n,
    input  logic       Key_enter,
    input  logic [7:0] Switches,
    input  logic [1:0] Op,
    output logic [7:0] Alu_A,
    output logic [7:0] Alu_B,
    output logic [1:0] Alu_op,
    output logic       Alu_start,
    input  logic       Alu_done,
    input  logic [7:0] Alu_result,
    input  logic       Alu_overflow,
    input  logic       Alu_carry,
    output logic [3:0] Units,
    output logic [3:0] Tens,
    output logic [1:0] Hundreds,
    output logic       Zero,
    output logic       Overflow,
    output logic       Carry_out,
    output logic       Busy
);
    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, CONV, SHOW} state_t;
    state_t state_q, state_d;
    logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0] op_q, op_d, hund_q, hund_d;
    logic [3:0] units_q, units_d, tens_q, tens_d;
    logic [2:0] cnt_q, cnt_d;
    logic [16:0] w_q, w_d;
    logic [17:0] w_sh;
    logic [3:0] tens_adj, units_adj;
    logic start_q, start_d, ovf_c_q, ovf_c_d, car_c_q, car_c_d;
    logic zero_q, zero_d, ovf_q, ovf_d, car_q, car_d;
`ifdef CALC_TIMEOUT_EN
    logic [3:0] wd_q, wd_d;
`endif
    // w holds {hundreds lsb, tens, units, binary}; hundreds stays below 2 until the final shift
    assign tens_adj  = (w_q[15:12] > 4'd4) ? w_q[15:12] + 4'd3 : w_q[15:12];
    assign units_adj = (w_q[11:8] > 4'd4) ? w_q[11:8] + 4'd3 : w_q[11:8];
    assign w_sh      = {w_q[16], tens_adj, units_adj, w_q[7:0], 1'b0};
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        start_d = 1'b0;
        res_d   = res_q;
        ovf_c_d = ovf_c_q;
        car_c_d = car_c_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        units_d = units_q;
        tens_d  = tens_q;
        hund_d  = hund_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        car_d   = car_q;
`ifdef CALC_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            WAIT_A: if (Key_enter) begin
                a_d     = Switches;
                state_d = WAIT_B;
            end
            WAIT_B: if (Key_enter) begin
                b_d     = Switches;
                state_d = WAIT_OP;
            end
            WAIT_OP: if (Key_enter) begin
                op_d    = Op;
                start_d = 1'b1;
                state_d = EXEC;
`ifdef CALC_TIMEOUT_EN
                wd_d    = 4'd0;
`endif
            end
            EXEC: if (Alu_done) begin
                res_d   = Alu_result;
                ovf_c_d = Alu_overflow;
                car_c_d = Alu_carry;
                w_d     = {9'd0, Alu_result};
                cnt_d   = 3'd0;
                state_d = CONV;
`ifdef CALC_TIMEOUT_EN
            end else if (wd_q == 4'hF) begin
                units_d = 4'd0;
                tens_d  = 4'd0;
                hund_d  = 2'd0;
                zero_d  = 1'b0;
                ovf_d   = 1'b1;
                car_d   = 1'b0;
                state_d = SHOW;
            end else begin
                wd_d    = wd_q + 4'd1;
`endif
            end
            CONV: begin
                w_d   = w_sh[16:0];
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    units_d = w_sh[11:8];
                    tens_d  = w_sh[15:12];
                    hund_d  = w_sh[17:16];
                    zero_d  = (res_q == 8'd0);
                    ovf_d   = ovf_c_q;
                    car_d   = car_c_q;
                    state_d = SHOW;
                end
            end
            SHOW: if (Key_enter) state_d = WAIT_A;
            default: state_d = WAIT_A;
        endcase
    end
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            start_q <= 1'b0;
            res_q   <= '0;
            ovf_c_q <= 1'b0;
            car_c_q <= 1'b0;
            w_q     <= '0;
            cnt_q   <= '0;
            units_q <= '0;
            tens_q  <= '0;
            hund_q  <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            car_q   <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            start_q <= start_d;
            res_q   <= res_d;
            ovf_c_q <= ovf_c_d;
            car_c_q <= car_c_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            hund_q  <= hund_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            car_q   <= car_d;
`ifdef CALC_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end
    assign Alu_A     = a_q;
    assign Alu_B     = b_q;
    assign Alu_op    = op_q;
    assign Alu_start = start_q;
    assign Units     = units_q;
    assign Tens      = tens_q;
    assign Hundreds  = hund_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign Carry_out = car_q;
    assign Busy      = (state_q == EXEC) || (state_q == CONV);
endmodule

// File: tb/tb_calc_controller.sv
// tb_calc_controller: directed self-checking bench for calc_controller.
module tb_calc_controller;
    logic       clock = 1'b0, Reset_n = 1'b0, Key_enter = 1'b0;
    logic [7:0] Switches = '0;
    logic [1:0] Op = '0;
    logic [7:0] Alu_A, Alu_B;
    logic [1:0] Alu_op;
    logic       Alu_start;
    logic       Alu_done = 1'b0;
    logic [7:0] Alu_result = '0;
    logic       Alu_overflow = 1'b0, Alu_carry = 1'b0;
    logic [3:0] Units, Tens;
    logic [1:0] Hundreds;
    logic       Zero, Overflow, Carry_out, Busy;
    int checks = 0, errors = 0;

    calc_controller dut (
        .clock(clock), .Reset_n(Reset_n), .Key_enter(Key_enter), .Switches(Switches), .Op(Op),
        .Alu_A(Alu_A), .Alu_B(Alu_B), .Alu_op(Alu_op), .Alu_start(Alu_start),
        .Alu_done(Alu_done), .Alu_result(Alu_result), .Alu_overflow(Alu_overflow), .Alu_carry(Alu_carry),
        .Units(Units), .Tens(Tens), .Hundreds(Hundreds), .Zero(Zero), .Overflow(Overflow),
        .Carry_out(Carry_out), .Busy(Busy)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic disp(input string tag, input int h, input int t, input int u, input bit z, input bit o, input bit c);
        chk({tag, " hundreds"}, {6'd0, Hundreds}, h[7:0]);
        chk({tag, " tens"}, {4'd0, Tens}, t[7:0]);
        chk({tag, " units"}, {4'd0, Units}, u[7:0]);
        chk({tag, " zero"}, {7'd0, Zero}, {7'd0, z});
        chk({tag, " overflow"}, {7'd0, Overflow}, {7'd0, o});
        chk({tag, " carry"}, {7'd0, Carry_out}, {7'd0, c});
    endtask

    task automatic enter(input logic [7:0] v);
        Switches  = v;
        Key_enter = 1'b1;
        tick();
        Key_enter = 1'b0;
    endtask

    task automatic entry(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        enter(a);
        enter(b);
        Op        = op;
        Key_enter = 1'b1;
        tick();
        Key_enter = 1'b0;
    endtask

    task automatic alu_done(input logic [7:0] r, input logic o, input logic c);
        Alu_done     = 1'b1;
        Alu_result   = r;
        Alu_overflow = o;
        Alu_carry    = c;
        tick();
        Alu_done     = 1'b0;
        Alu_result   = '0;
        Alu_overflow = 1'b0;
        Alu_carry    = 1'b0;
    endtask

    initial begin
        tick(2);
        disp("reset", 0, 0, 0, 0, 0, 0);
        chk("reset busy", {7'd0, Busy}, 8'd0);
        chk("reset start", {7'd0, Alu_start}, 8'd0);
        chk("reset A", Alu_A, 8'd0);
        Reset_n = 1'b1;
        tick();
        // 200 + 55 = 255
        entry(8'd200, 8'd55, 2'd0);
        chk("A latched", Alu_A, 8'd200);
        chk("B latched", Alu_B, 8'd55);
        chk("op latched", {6'd0, Alu_op}, 8'd0);
        chk("start pulse", {7'd0, Alu_start}, 8'd1);
        chk("busy exec", {7'd0, Busy}, 8'd1);
        alu_done(8'd255, 1'b0, 1'b0);
        chk("start one cycle", {7'd0, Alu_start}, 8'd0);
        chk("busy conv", {7'd0, Busy}, 8'd1);
        tick(7);
        disp("255 at k+7", 0, 0, 0, 0, 0, 0);
        tick();
        disp("255 at k+8", 2, 5, 5, 0, 0, 0);
        chk("busy show", {7'd0, Busy}, 8'd0);
        // zero result with carry
        Key_enter = 1'b1;
        tick();
        Key_enter = 1'b0;
        entry(8'd10, 8'd20, 2'd1);
        chk("op 1", {6'd0, Alu_op}, 8'd1);
        alu_done(8'd0, 1'b0, 1'b1);
        tick(7);
        disp("hold 255", 2, 5, 5, 0, 0, 0);
        tick();
        disp("zero carry", 0, 0, 0, 1, 0, 1);
        // Key_enter held through EXEC and CONV
        Key_enter = 1'b1;
        tick();
        Key_enter = 1'b0;
        entry(8'd100, 8'd23, 2'd2);
        Key_enter = 1'b1;
        Switches  = 8'd77;
        tick(3);
        chk("busy exec key", {7'd0, Busy}, 8'd1);
        chk("A held exec key", Alu_A, 8'd100);
        alu_done(8'd123, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            chk("busy conv key", {7'd0, Busy}, 8'd1);
            tick();
        end
        chk("busy conv key last", {7'd0, Busy}, 8'd1);
        tick();
        Key_enter = 1'b0;
        disp("123 with keys", 1, 2, 3, 0, 1, 0);
        chk("A held after keys", Alu_A, 8'd100);
        chk("busy show after keys", {7'd0, Busy}, 8'd0);
        tick(2);
        chk("stays in show", Alu_A, 8'd100);
        // reset in CONV cycle 4
        Key_enter = 1'b1;
        tick();
        Key_enter = 1'b0;
        entry(8'd9, 8'd9, 2'd3);
        alu_done(8'd200, 1'b0, 1'b1);
        tick(3);
        Reset_n = 1'b0;
        #1;
        disp("async reset", 0, 0, 0, 0, 0, 0);
        chk("async reset busy", {7'd0, Busy}, 8'd0);
        chk("async reset A", Alu_A, 8'd0);
        chk("async reset op", {6'd0, Alu_op}, 8'd0);
        tick();
        Reset_n = 1'b1;
        tick(10);
        disp("no update after abort", 0, 0, 0, 0, 0, 0);
        enter(8'd42);
        chk("wait_a after reset", Alu_A, 8'd42);
        // 99 then a new sequence must keep 0/9/9 until its own update
        enter(8'd57);
        Op        = 2'd0;
        Key_enter = 1'b1;
        tick();
        Key_enter = 1'b0;
        alu_done(8'd99, 1'b0, 1'b0);
        tick(8);
        disp("99", 0, 9, 9, 0, 0, 0);
        Key_enter = 1'b1;
        tick();
        Key_enter = 1'b0;
        disp("99 wait_a", 0, 9, 9, 0, 0, 0);
        enter(8'd1);
        disp("99 wait_b", 0, 9, 9, 0, 0, 0);
        enter(8'd2);
        disp("99 wait_op", 0, 9, 9, 0, 0, 0);
        Op        = 2'd3;
        Key_enter = 1'b1;
        tick();
        Key_enter = 1'b0;
        disp("99 exec", 0, 9, 9, 0, 0, 0);
        alu_done(8'd7, 1'b0, 1'b0);
        tick(7);
        disp("99 conv k+7", 0, 9, 9, 0, 0, 0);
        tick();
        disp("7", 0, 0, 7, 0, 0, 0);
        // ALU never answers
        Key_enter = 1'b1;
        tick();
        Key_enter = 1'b0;
        entry(8'd0, 8'd0, 2'd0);
`ifdef CALC_TIMEOUT_EN
        tick(15);
        chk("watchdog not yet", {7'd0, Busy}, 8'd1);
        tick();
        chk("watchdog fired", {7'd0, Busy}, 8'd0);
        disp("timeout", 0, 0, 0, 0, 1, 0);
`else
        tick(100);
        chk("exec waits forever", {7'd0, Busy}, 8'd1);
        disp("no timeout", 0, 0, 7, 0, 0, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
